sonar_uc: RTL

Control unit for the sonar: a Moore FSM that sequences the sonar datapath through position, settle, measure and transmit for each servo position. Each position produces one 8-character serial frame (angle, separator, distance, terminator). The block sits directly upstream of the datapath and drives every control input of it. It consumes the datapath's `fim_*` status flags.

---
 rtl/sonar_pkg.sv | 20 ++
 rtl/contador_m.sv | 25 ++
 rtl/sonar_uc.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sonar_pkg.sv
// Shared encodings and constants for the sonar control unit.
package sonar_pkg;

  typedef enum logic [3:0] {
    INICIAL            = 4'h0,
    PREPARACAO         = 4'h1,
    ESPERA_INTERVALO   = 4'h2,
    MEDIDA             = 4'h3,
    ESPERA_MEDIDA      = 4'h4,
    TRANSMISSAO        = 4'h5,
    ESPERA_TRANSMISSAO = 4'h6,
    PROXIMO_CARACTERE  = 4'h7,
    PROXIMA_POSICAO    = 4'h8,
    FALHA_MEDIDA       = 4'hE
  } estado_t;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1_500_000;
  localparam int unsigned FRAME_LEN          = 8;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear and a terminal-count flag.
module contador_m #(
  parameter int unsigned M = 100,
  parameter int unsigned N = 7
) (
  input  logic clock,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] q;

  always_ff @(posedge clock) begin
    if (zera_s) begin
      q <= '0;
    end else if (conta) begin
      if (q == N'(M - 1)) q <= '0;
      else                q <= q + 1'b1;
    end
  end

  assign fim = (q == N'(M - 1));

endmodule

// File: rtl/sonar_uc.sv
// Moore control unit sequencing the sonar datapath per servo position.
// Define SONAR_TIMEOUT_EN to compile in the echo watchdog and the falha_medida path.
//
// state              | meaning
// inicial            | idle, servo PWM held off
// preparacao         | clear datapath counters and position
// espera_intervalo   | servo settling
// medida             | start measurement
// espera_medida      | wait for echo (watchdog armed with macro)
// transmissao        | start one serial character
// espera_transmissao | wait for character sent
// proximo_caractere  | advance character counter
// proxima_posicao    | frame done, advance servo
// falha_medida       | echo timeout, skip frame and advance servo
module sonar_uc
  import sonar_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_distancia,
  input  logic       fim_transmissao,
  input  logic       fim_contador_serial,
  input  logic       fim_contador_intervalo,
  output logic       zera,
  output logic       zera_pwm,
  output logic       reset_updown,
  output logic       conta_intervalo,
  output logic       medir,
  output logic       transmitir,
  output logic       conta_serial,
  output logic       conta_updown,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  estado_t estado, proximo;

  always_ff @(posedge clock) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

`ifdef SONAR_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic wd_fim;

  // Cleared while in medida so the count starts at 0 on the first espera_medida cycle.
  contador_m #(.M(TIMEOUT_CYCLES), .N(WD_W)) u_watchdog (
    .clock  (clock),
    .zera_s (reset || (estado == MEDIDA)),
    .conta  (estado == ESPERA_MEDIDA),
    .fim    (wd_fim)
  );
`else
  assign erro = 1'b0;
`endif

  always_comb begin
    proximo         = INICIAL;
    zera            = 1'b0;
    zera_pwm        = 1'b0;
    reset_updown    = 1'b0;
    conta_intervalo = 1'b0;
    medir           = 1'b0;
    transmitir      = 1'b0;
    conta_serial    = 1'b0;
    conta_updown    = 1'b0;
    pronto          = 1'b0;
`ifdef SONAR_TIMEOUT_EN
    erro            = 1'b0;
`endif
    case (estado)
      INICIAL: begin
        zera_pwm = 1'b1;
        proximo  = ligar ? PREPARACAO : INICIAL;
      end
      PREPARACAO: begin
        zera         = 1'b1;
        reset_updown = 1'b1;
        zera_pwm     = 1'b1;
        proximo      = ESPERA_INTERVALO;
      end
      ESPERA_INTERVALO: begin
        conta_intervalo = 1'b1;
        proximo = fim_contador_intervalo ? MEDIDA : ESPERA_INTERVALO;
      end
      MEDIDA: begin
        medir   = 1'b1;
        proximo = ESPERA_MEDIDA;
      end
      ESPERA_MEDIDA: begin
        // A measurement completing in the expiry cycle takes priority.
        if (fim_distancia)  proximo = TRANSMISSAO;
`ifdef SONAR_TIMEOUT_EN
        else if (wd_fim)    proximo = FALHA_MEDIDA;
`endif
        else                proximo = ESPERA_MEDIDA;
      end
      TRANSMISSAO: begin
        transmitir = 1'b1;
        proximo    = ESPERA_TRANSMISSAO;
      end
      ESPERA_TRANSMISSAO: begin
        if (fim_transmissao)
          proximo = fim_contador_serial ? PROXIMA_POSICAO : PROXIMO_CARACTERE;
        else
          proximo = ESPERA_TRANSMISSAO;
      end
      PROXIMO_CARACTERE: begin
        conta_serial = 1'b1;
        proximo      = TRANSMISSAO;
      end
      PROXIMA_POSICAO: begin
        conta_serial = 1'b1;
        conta_updown = 1'b1;
        pronto       = 1'b1;
        proximo      = ligar ? ESPERA_INTERVALO : INICIAL;
      end
`ifdef SONAR_TIMEOUT_EN
      FALHA_MEDIDA: begin
        erro         = 1'b1;
        conta_updown = 1'b1;
        proximo      = ligar ? ESPERA_INTERVALO : INICIAL;
      end
`endif
      default: proximo = INICIAL;
    endcase
  end

  assign db_estado = estado;

endmodule
